lcd_timing_gen: RTL and testbench



---
 rtl/lcd_timing_pkg.sv | 36 +++
 rtl/lcd_timing_gen_if.sv | 34 +++
 rtl/lcd_axis_counter.sv | 48 ++++
 rtl/lcd_timing_gen.sv | 149 ++++++++++++++
 tb/tb_lcd_timing_gen.sv | 349 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lcd_timing_pkg.sv
// Shared types and default 1024x600 panel timing for the LCD raster generator.
package lcd_timing_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        STOPPING
    } state_t;

    localparam int DEF_H_ACTIVE = 1024;
    localparam int DEF_H_FP     = 160;
    localparam int DEF_H_SYNC   = 20;
    localparam int DEF_H_BP     = 140;
    localparam int DEF_V_ACTIVE = 600;
    localparam int DEF_V_FP     = 12;
    localparam int DEF_V_SYNC   = 3;
    localparam int DEF_V_BP     = 20;

    // Boundaries along one axis, in order sync | back porch | active | front porch.
    typedef struct packed {
        logic [31:0] sync_end;
        logic [31:0] act_start;
        logic [31:0] act_end;
        logic [31:0] total;
    } region_t;

    function automatic region_t lcd_region(int sync_w, int bp_w, int act_w, int fp_w);
        region_t r;
        r.sync_end  = 32'(sync_w);
        r.act_start = 32'(sync_w + bp_w);
        r.act_end   = 32'(sync_w + bp_w + act_w);
        r.total     = 32'(sync_w + bp_w + act_w + fp_w);
        return r;
    endfunction

endpackage

// File: rtl/lcd_timing_gen_if.sv
// Control and timing bundle between lcd_timing_gen (master) and the panel side.
// LCD_TIMING_LINE_IRQ_EN adds irq_line / line_irq.
interface lcd_timing_gen_if #(
    parameter int XW = 10,
    parameter int YW = 10
`ifdef LCD_TIMING_LINE_IRQ_EN
    , parameter int VW = 10
`endif
);
    logic          en;
    logic          mode_de;
    logic          hsync;
    logic          vsync;
    logic          data_en;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          line_start;
    logic          frame_start;
    logic          busy;
`ifdef LCD_TIMING_LINE_IRQ_EN
    logic [VW-1:0] irq_line;
    logic          line_irq;

    modport master (input en, mode_de, irq_line,
                    output hsync, vsync, data_en, x, y, line_start, frame_start, busy, line_irq);
    modport slave  (output en, mode_de, irq_line,
                    input hsync, vsync, data_en, x, y, line_start, frame_start, busy, line_irq);
`else
    modport master (input en, mode_de,
                    output hsync, vsync, data_en, x, y, line_start, frame_start, busy);
    modport slave  (output en, mode_de,
                    input hsync, vsync, data_en, x, y, line_start, frame_start, busy);
`endif
endinterface

// File: rtl/lcd_axis_counter.sv
// Wrapping position counter for one raster axis with sync/active region decode.
module lcd_axis_counter #(
    parameter int TOTAL     = 8,
    parameter int SYNC_END  = 1,
    parameter int ACT_START = 2,
    parameter int ACT_END   = 6,
    parameter int W         = $clog2(TOTAL)
) (
    input  logic         clock,
    input  logic         reset_L,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt,
    output logic         tc,
    output logic         in_sync,
    output logic         in_active
);
    localparam logic [W-1:0] LAST        = W'(TOTAL - 1);
    localparam logic [W-1:0] SYNC_END_W  = W'(SYNC_END);
    localparam logic [W-1:0] ACT_START_W = W'(ACT_START);
    // Inclusive upper bound keeps the constant inside W bits even with no front porch.
    localparam logic [W-1:0] ACT_LAST_W  = W'(ACT_END - 1);

    logic [W-1:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt       = cnt_q;
    assign tc        = (cnt_q == LAST);
    assign in_sync   = (cnt_q < SYNC_END_W);
    assign in_active = (cnt_q >= ACT_START_W) && (cnt_q <= ACT_LAST_W);

endmodule

// File: rtl/lcd_timing_gen.sv
// LCD raster timing generator: HV or DE-only timing with frame-complete stop.
// Optional LCD_TIMING_LINE_IRQ_EN adds a programmable per-frame line interrupt.
module lcd_timing_gen
    import lcd_timing_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit HS_POL   = 1'b1,
    parameter bit VS_POL   = 1'b1,
    parameter bit DE_POL   = 1'b1
) (
    input  logic             clock,
    input  logic             reset_L,
    lcd_timing_gen_if.master bus
);
    localparam region_t H_R = lcd_region(H_SYNC, H_BP, H_ACTIVE, H_FP);
    localparam region_t V_R = lcd_region(V_SYNC, V_BP, V_ACTIVE, V_FP);
    localparam int H_TOTAL  = int'(H_R.total);
    localparam int V_TOTAL  = int'(V_R.total);
    localparam int HW       = $clog2(H_TOTAL);
    localparam int VW       = $clog2(V_TOTAL);
    localparam int XW       = $clog2(H_ACTIVE);
    localparam int YW       = $clog2(V_ACTIVE);
    localparam logic [HW-1:0] H_ACT_START = HW'(H_R.act_start);
    localparam logic [VW-1:0] V_ACT_START = VW'(V_R.act_start);

    state_t        state_q, state_d;
    logic          mode_q, mode_d;
    logic          busy_q, busy_d;
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic          data_en_q, data_en_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic          line_start_q, line_start_d;
    logic          frame_start_q, frame_start_d;

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          h_tc, v_tc, h_sync, v_sync, h_act, v_act;
    logic          run, frame_end, de_on;

    assign run       = (state_q != IDLE);
    assign frame_end = h_tc && v_tc;
    assign de_on     = run && h_act && v_act;

    lcd_axis_counter #(
        .TOTAL(H_TOTAL), .SYNC_END(int'(H_R.sync_end)), .ACT_START(int'(H_R.act_start)),
        .ACT_END(int'(H_R.act_end)), .W(HW)
    ) u_h_axis (
        .clock(clock), .reset_L(reset_L), .inc(run), .clr(!run),
        .cnt(h_cnt), .tc(h_tc), .in_sync(h_sync), .in_active(h_act)
    );

    lcd_axis_counter #(
        .TOTAL(V_TOTAL), .SYNC_END(int'(V_R.sync_end)), .ACT_START(int'(V_R.act_start)),
        .ACT_END(int'(V_R.act_end)), .W(VW)
    ) u_v_axis (
        .clock(clock), .reset_L(reset_L), .inc(run && h_tc), .clr(!run),
        .cnt(v_cnt), .tc(v_tc), .in_sync(v_sync), .in_active(v_act)
    );

    // Outputs decode this cycle's counters and appear one clock later.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:     if (bus.en) state_d = RUN;
            RUN:      if (!bus.en) state_d = STOPPING;
            STOPPING: begin
                if (bus.en) state_d = RUN;
                else if (frame_end) state_d = IDLE;
            end
            default:  state_d = IDLE;
        endcase
        busy_d        = (state_d != IDLE);
        mode_d        = (!run || frame_end) ? bus.mode_de : mode_q;
        hsync_d       = (run && !mode_q && h_sync) ? HS_POL : ~HS_POL;
        vsync_d       = (run && !mode_q && v_sync) ? VS_POL : ~VS_POL;
        data_en_d     = de_on ? DE_POL : ~DE_POL;
        x_d           = de_on ? XW'(h_cnt - H_ACT_START) : '0;
        y_d           = de_on ? YW'(v_cnt - V_ACT_START) : '0;
        line_start_d  = run && (h_cnt == '0);
        frame_start_d = run && (h_cnt == '0) && (v_cnt == '0);
    end

    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            state_q       <= IDLE;
            mode_q        <= 1'b0;
            busy_q        <= 1'b0;
            hsync_q       <= ~HS_POL;
            vsync_q       <= ~VS_POL;
            data_en_q     <= ~DE_POL;
            x_q           <= '0;
            y_q           <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            mode_q        <= mode_d;
            busy_q        <= busy_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            data_en_q     <= data_en_d;
            x_q           <= x_d;
            y_q           <= y_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign bus.hsync       = hsync_q;
    assign bus.vsync       = vsync_q;
    assign bus.data_en     = data_en_q;
    assign bus.x           = x_q;
    assign bus.y           = y_q;
    assign bus.line_start  = line_start_q;
    assign bus.frame_start = frame_start_q;
    assign bus.busy        = busy_q;

`ifdef LCD_TIMING_LINE_IRQ_EN
    logic [VW-1:0] irq_line_q, irq_line_d;
    logic          line_irq_q, line_irq_d;

    always_comb begin
        irq_line_d = (!run || frame_end) ? bus.irq_line : irq_line_q;
        line_irq_d = run && (h_cnt == '0) && (v_cnt == irq_line_q);
    end

    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            irq_line_q <= '0;
            line_irq_q <= 1'b0;
        end else begin
            irq_line_q <= irq_line_d;
            line_irq_q <= line_irq_d;
        end
    end

    assign bus.line_irq = line_irq_q;
`endif

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Bench for lcd_timing_gen on an 8x6 raster, active-high and active-low builds side by side.
module tb_lcd_timing_gen;
    localparam int H_ACTIVE = 4, H_FP = 2, H_SYNC = 1, H_BP = 1, H_TOTAL = 8;
    localparam int V_ACTIVE = 3, V_FP = 1, V_SYNC = 1, V_BP = 1, V_TOTAL = 6;
    localparam int FRAME = H_TOTAL * V_TOTAL;
    localparam int XW = 2, YW = 2, VW = 3;
    localparam logic [10:0] IDLE_V = 11'b0;

    logic          clock = 1'b0;
    logic          reset_L = 1'b1;
    logic          en = 1'b0;
    logic          mode_de = 1'b0;
    logic [VW-1:0] irq_line = 3'd3;
    int            vectors = 0;
    int            miscompares = 0;
    int            cyc = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    lcd_timing_gen_if #(.XW(XW), .YW(YW)
`ifdef LCD_TIMING_LINE_IRQ_EN
        , .VW(VW)
`endif
    ) bus_p (), bus_n ();

    assign bus_p.en = en;
    assign bus_n.en = en;
    assign bus_p.mode_de = mode_de;
    assign bus_n.mode_de = mode_de;

    lcd_timing_gen #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .HS_POL(1'b1), .VS_POL(1'b1), .DE_POL(1'b1)
    ) dut (.clock(clock), .reset_L(reset_L), .bus(bus_p));

    lcd_timing_gen #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .HS_POL(1'b0), .VS_POL(1'b0), .DE_POL(1'b0)
    ) dut_n (.clock(clock), .reset_L(reset_L), .bus(bus_n));

    logic irq_p, irq_n;
`ifdef LCD_TIMING_LINE_IRQ_EN
    assign bus_p.irq_line = irq_line;
    assign bus_n.irq_line = irq_line;
    assign irq_p = bus_p.line_irq;
    assign irq_n = bus_n.line_irq;
`else
    assign irq_p = 1'b0;
    assign irq_n = 1'b0;
`endif

    // Layout: {hsync, vsync, data_en, x[1:0], y[1:0], line_start, frame_start, busy, line_irq}
    logic [10:0] obs_p, obs_n, exp_v;
    assign obs_p = {bus_p.hsync, bus_p.vsync, bus_p.data_en, bus_p.x, bus_p.y,
                    bus_p.line_start, bus_p.frame_start, bus_p.busy, irq_p};
    assign obs_n = {~bus_n.hsync, ~bus_n.vsync, ~bus_n.data_en, bus_n.x, bus_n.y,
                    bus_n.line_start, bus_n.frame_start, bus_n.busy, irq_n};

    // Reference: position within the frame plus run/stop flags, outputs from region arithmetic.
    bit            m_busy, m_stop, m_mode;
    int            m_pos;
    logic [VW-1:0] m_irq;
    always @(posedge clock or negedge reset_L) begin
        int h, v;
        bit last, nb;
        logic [10:0] e;
        if (!reset_L) begin
            m_busy <= 0; m_stop <= 0; m_mode <= 0; m_pos <= 0; m_irq <= '0; exp_v <= '0;
        end else begin
            h = m_pos % H_TOTAL;
            v = m_pos / H_TOTAL;
            last = (m_pos == FRAME - 1);
            e = '0;
            if (m_busy) begin
                e[10] = !m_mode && (h < H_SYNC);
                e[9]  = !m_mode && (v < V_SYNC);
                if (h >= H_SYNC + H_BP && h < H_SYNC + H_BP + H_ACTIVE &&
                    v >= V_SYNC + V_BP && v < V_SYNC + V_BP + V_ACTIVE) begin
                    e[8]   = 1'b1;
                    e[7:6] = 2'(h - (H_SYNC + H_BP));
                    e[5:4] = 2'(v - (V_SYNC + V_BP));
                end
                e[3] = (h == 0);
                e[2] = (m_pos == 0);
`ifdef LCD_TIMING_LINE_IRQ_EN
                e[0] = (h == 0) && (v == int'(m_irq));
`endif
            end
            if (!m_busy) begin
                nb = en;
                m_mode <= mode_de; m_irq <= irq_line; m_pos <= 0; m_stop <= 0;
            end else begin
                nb = !(m_stop && !en && last);
                if (last) begin m_mode <= mode_de; m_irq <= irq_line; end
                if (!nb) begin
                    m_pos <= 0;
                end else begin
                    m_pos <= (m_pos + 1) % FRAME;
                    m_stop <= !en;
                end
            end
            m_busy <= nb;
            e[1] = nb;
            exp_v <= e;
        end
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) @(negedge clock);
    endtask

    task automatic wait_fs(output bit ok);
        ok = 0;
        for (int i = 0; i < 2 * FRAME && !ok; i++) begin
            @(negedge clock);
            ok = bus_p.frame_start;
        end
    endtask

    task automatic test_reset();
        #1 reset_L = 1'b0;
        #3;
        if (obs_p !== IDLE_V || obs_n !== IDLE_V) begin
            miscompares++;
            $display("FAIL reset_state got %b / %b want %b", obs_p, obs_n, IDLE_V);
        end
        vectors++;
        step(3);
        reset_L = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            if (obs_p !== IDLE_V || obs_n !== IDLE_V || exp_v !== IDLE_V) begin
                miscompares++;
                $display("FAIL idle_after_reset got %b / %b want %b", obs_p, obs_n, IDLE_V);
            end
            vectors++;
        end
    endtask

    task automatic test_run();
        int first = -1, n_de = 0, n_ls = 0, n_vs = 0, n_hs_bad = 0, n_vs_fs_bad = 0;
        int k = 0, xy_bad = 0, n_irq = 0, irq_bad = 0, ls_idx = 0;
        int fs_cyc[$];
        mode_de = 1'b0;
        en = 1'b1;
        for (int i = 1; i <= 2 * FRAME + 1; i++) begin
            @(negedge clock);
            if (obs_p !== exp_v || obs_n !== exp_v) begin
                miscompares++;
                $display("FAIL run_model cyc=%0d got %b / %b want %b", cyc, obs_p, obs_n, exp_v);
            end
            vectors++;
            if (bus_p.frame_start) begin
                if (first < 0) first = i;
                fs_cyc.push_back(cyc);
                if (!bus_p.vsync) n_vs_fs_bad++;
            end
            if (i >= 2) begin
                if (bus_p.data_en) begin
                    if (bus_p.x !== 2'(k % 4) || bus_p.y !== 2'((k / 4) % 3)) xy_bad++;
                    k++;
                    n_de++;
                end
                if (bus_p.line_start) begin
                    n_ls++;
                    ls_idx = bus_p.frame_start ? 1 : ls_idx + 1;
                end
                if (bus_p.vsync) n_vs++;
                if (bus_p.hsync !== bus_p.line_start) n_hs_bad++;
                if (irq_p) begin
                    n_irq++;
                    if (!bus_p.line_start || ls_idx != 4) irq_bad++;
                end
            end
        end
        if (first !== 2) begin miscompares++; $display("FAIL first_frame_start got cycle %0d want 2", first); end
        vectors++;
        if (n_de !== 24 || xy_bad !== 0) begin
            miscompares++; $display("FAIL data_en_xy got %0d de, %0d bad xy want 24, 0", n_de, xy_bad);
        end
        vectors++;
        if (n_ls !== 12 || n_hs_bad !== 0) begin
            miscompares++; $display("FAIL line_hsync got %0d ls, %0d hs mismatches want 12, 0", n_ls, n_hs_bad);
        end
        vectors++;
        if (n_vs !== 16 || n_vs_fs_bad !== 0) begin
            miscompares++; $display("FAIL vsync got %0d high, %0d misaligned want 16, 0", n_vs, n_vs_fs_bad);
        end
        vectors++;
        if (fs_cyc.size() !== 2 || fs_cyc[1] - fs_cyc[0] !== FRAME) begin
            miscompares++; $display("FAIL frame_spacing got %0d pulses want 2 spaced %0d", fs_cyc.size(), FRAME);
        end
        vectors++;
`ifdef LCD_TIMING_LINE_IRQ_EN
        if (n_irq !== 2 || irq_bad !== 0) begin
            miscompares++; $display("FAIL line_irq got %0d pulses, %0d misplaced want 2, 0", n_irq, irq_bad);
        end
        vectors++;
`endif
    endtask

    task automatic test_mode_switch();
        bit ok;
        int n_hs = 0, n_vs = 0, n_de = 0, n_ls = 0;
        wait_fs(ok);
        step(20);
        mode_de = 1'b1;
        ok = 0;
        for (int i = 0; i < 2 * FRAME && !ok; i++) begin
            if (bus_p.hsync) n_hs++;
            @(negedge clock);
            ok = bus_p.frame_start;
        end
        if (n_hs !== 3 || !ok) begin
            miscompares++; $display("FAIL mode_midframe got %0d hsync pulses (fs=%0d) want 3", n_hs, ok);
        end
        vectors++;
        for (int i = 0; i < FRAME; i++) begin
            if (i > 0) @(negedge clock);
            if (obs_p !== exp_v || obs_n !== exp_v) begin
                miscompares++;
                $display("FAIL de_mode_model cyc=%0d got %b / %b want %b", cyc, obs_p, obs_n, exp_v);
            end
            vectors++;
            n_hs += int'(bus_p.hsync);
            n_vs += int'(bus_p.vsync);
            n_de += int'(bus_p.data_en);
            n_ls += int'(bus_p.line_start);
        end
        if (n_hs !== 3 || n_vs !== 0 || n_de !== 12 || n_ls !== 6) begin
            miscompares++;
            $display("FAIL de_mode_frame got hs=%0d vs=%0d de=%0d ls=%0d want 0,0,12,6", n_hs - 3, n_vs, n_de, n_ls);
        end
        vectors++;
        mode_de = 1'b0;
    endtask

    task automatic test_stop();
        bit ok;
        int n = 0;
        wait_fs(ok);
        step(9);
        en = 1'b0;
        while (bus_p.busy && n < 100) begin
            n++;
            @(negedge clock);
        end
        if (n !== 38) begin miscompares++; $display("FAIL stop_busy got %0d busy cycles want 38", n); end
        vectors++;
        for (int i = 0; i < 6; i++) begin
            if (obs_p !== IDLE_V || obs_n !== IDLE_V || exp_v !== IDLE_V) begin
                miscompares++; $display("FAIL stop_idle got %b / %b want %b", obs_p, obs_n, IDLE_V);
            end
            vectors++;
            @(negedge clock);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int c0, n_idle = 0;
        en = 1'b1;
        wait_fs(ok);
        c0 = cyc;
        step(9);
        en = 1'b0;
        step(5);
        en = 1'b1;
        wait_fs(ok);
        if (!ok || cyc - c0 !== FRAME) begin
            miscompares++; $display("FAIL restart_early got spacing %0d want %0d", cyc - c0, FRAME);
        end
        vectors++;
        c0 = cyc;
        step(39);
        en = 1'b0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clock);
            if (!bus_p.busy) n_idle++;
        end
        en = 1'b1;
        wait_fs(ok);
        if (!ok || cyc - c0 !== FRAME || n_idle !== 0) begin
            miscompares++;
            $display("FAIL restart_boundary got spacing %0d idle %0d want %0d, 0", cyc - c0, n_idle, FRAME);
        end
        vectors++;
    endtask

    task automatic test_async_reset();
        int first = -1;
        for (int i = 0; i < 2 * FRAME && !bus_p.data_en; i++) @(negedge clock);
        #2 reset_L = 1'b0;
        #1;
        if (obs_p !== IDLE_V || obs_n !== IDLE_V) begin
            miscompares++; $display("FAIL async_reset got %b / %b want %b", obs_p, obs_n, IDLE_V);
        end
        vectors++;
        @(negedge clock);
        reset_L = 1'b1;
        for (int i = 1; i <= FRAME + 2; i++) begin
            @(negedge clock);
            if (obs_p !== exp_v || obs_n !== exp_v) begin
                miscompares++;
                $display("FAIL restart_model cyc=%0d got %b / %b want %b", cyc, obs_p, obs_n, exp_v);
            end
            vectors++;
            if (bus_p.frame_start && first < 0) first = i;
        end
        if (first !== 2) begin miscompares++; $display("FAIL restart_first_fs got cycle %0d want 2", first); end
        vectors++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            @(negedge clock);
            if (obs_p !== exp_v || obs_n !== exp_v) begin
                miscompares++;
                $display("FAIL random cyc=%0d got %b / %b want %b", cyc, obs_p, obs_n, exp_v);
            end
            vectors++;
            if ($urandom_range(0, 59) == 0) en = ~en;
            if ($urandom_range(0, 89) == 0) mode_de = ~mode_de;
            if ($urandom_range(0, 99) == 0) irq_line = 3'($urandom_range(0, V_TOTAL - 1));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_run();
        test_mode_switch();
        test_stop();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
